lag_counter: RTL and testbench
==============================

Name: lag_counter

Overview:
- Measures input lag: counts time from the `starttrigger` pulse emitted by the video stage until the photosensor detects the flashed field.
- Produces the 80-bit `bcdcount` bus consumed by the video stage's text generator. The bus packs four 5-digit BCD fields: last, min, max, sample count.
- Sits directly upstream of `video`, in the pixel clock domain.

Parameters:
- TIMEOUT_BCD, 20'h09999, lag value (BCD, in units) at which a measurement is abandoned without updating stats.
- SYNC_STAGES, 2, synchroniser depth on the asynchronous `sensor` input (minimum 2).

Ports:
- clock  input  1  pixel clock, same clock as `video`.
- reset_n  input  1  asynchronous active-low reset.
- starttrigger  input  1  single-cycle pulse from `video` marking flash start.
- sensor  input  1  asynchronous photodiode comparator output; high = light detected.
- ticks_per_unit  input  18  clocks per 0.1 ms unit; sampled at measurement start; 0 is treated as 1.
- clear_stats  input  1  synchronous pulse that resets min/max/count/last.
- bcdcount  output  80  {last[79:60], min[59:40], max[39:20], count[19:0]}, 5 BCD digits each.
- measuring  output  1  high while in MEASURE.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE; last = 00000; min = 99999; max = 00000; count = 00000.
  - measuring = 0; prescaler = 0; lag accumulator = 00000; synchroniser flops = 0.
- Sensor path:
  - SYNC_STAGES flop chain, then a registered copy for edge detection.
  - Rising edge `sensor_rise` is asserted SYNC_STAGES+1 clocks after the pin rises.
- State IDLE:
  - On starttrigger: go to MEASURE, clear accumulator and prescaler, latch max(ticks_per_unit,1).
  - measuring rises in the cycle after the trigger.
- State MEASURE:
  - Prescaler counts 0..latched-1. At wrap, the accumulator increments by one BCD unit: decimal carry per digit, 9→0 with carry.
  - On `sensor_rise` (edge only; a level already high at start does not count):
    - last <= accumulator, using the value in that cycle, before any same-cycle increment.
    - min <= accumulator if accumulator < min.
    - max <= accumulator if accumulator > max.
    - Comparisons are plain 20-bit unsigned; valid BCD preserves ordering.
    - count increments in BCD, saturating at 99999.
    - Go to HOLD.
  - All stat updates are visible on `bcdcount` one clock after the `sensor_rise` cycle.
  - If accumulator == TIMEOUT_BCD: go to IDLE, stats unchanged.
  - starttrigger while in MEASURE is ignored and does not restart.
- State HOLD:
  - Wait until synced sensor == 0, then go to IDLE.
  - Prevents a still-lit sensor from being consumed by the next trigger.
  - starttrigger in HOLD is ignored.
- Simultaneous events:
  - `sensor_rise` and timeout in the same cycle: the sensor wins and stats update.
  - starttrigger and `sensor_rise` in IDLE: the trigger is taken, and the edge is not counted for this measurement.
- clear_stats:
  - Any state; does not affect the FSM or accumulator.
  - If coincident with a stat update, clear wins.
- Reset mid-measurement: everything returns to reset values immediately.
- `bcdcount` is fully registered; no combinational path from inputs.

Test Plan:
1. Basic measurement:
   - Stimulus: ticks_per_unit=4; starttrigger; sensor rises 50 clocks later.
   - Required: last=00012 or 00011, consistent with the sync+edge latency formula. min=max=last; count=00001; measuring low again once HOLD exits after sensor falls.
2. Min/max tracking:
   - Stimulus: three measurements at 20, 100, 60 units (ticks_per_unit=1). Sensor drops between them.
   - Required: min=00020, max=00100, last=00060, count=00003.
3. BCD carry:
   - Stimulus: lag reaching 00999 → 01000 (ticks_per_unit=1).
   - Required: digits roll 00999→01000 with no A–F nibbles, checked every increment.
4. Timeout:
   - Stimulus: TIMEOUT_BCD=20'h00050; no sensor edge.
   - Required: after 50 units the FSM returns to IDLE; stats unchanged; count stays at its prior value.
5. Sensor already high and trigger during HOLD:
   - Stimulus: sensor held high before starttrigger.
   - Required: no capture until a fall and a new rise. A starttrigger issued during HOLD produces no new measurement.
6. Clear and reset:
   - Stimulus: clear_stats coincident with `sensor_rise`.
   - Required: stats read 00000/99999/00000/00000.
   - Stimulus: reset_n pulsed low mid-MEASURE.
   - Required: immediate reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/lag_counter_if.sv
// Trigger/sensor inputs and packed BCD statistics output of the lag counter.
// Pure wiring bundle; no timing of its own.
interface lag_counter_if;
  logic        starttrigger;
  logic        sensor;
  logic [17:0] ticks_per_unit;
  logic        clear_stats;
  logic [79:0] bcdcount;
  logic        measuring;

  modport master (
    output starttrigger, sensor, ticks_per_unit, clear_stats,
    input  bcdcount, measuring
  );

  modport slave (
    input  starttrigger, sensor, ticks_per_unit, clear_stats,
    output bcdcount, measuring
  );
endinterface

// File: rtl/lag_counter.sv
// Video input-lag meter: trigger-to-photosensor time in 0.1 ms BCD units, with last/min/max/count stats.
// Stats land one clock after the synchronised sensor edge; no backpressure, inputs are sampled every clock.
module lag_counter #(
  parameter logic [19:0] TIMEOUT_BCD = 20'h09999,
  parameter int          SYNC_STAGES = 2
) (
  input logic        clock,
  input logic        reset_n,
  lag_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;

  typedef struct packed {
    logic [19:0] last;
    logic [19:0] min;
    logic [19:0] max;
    logic [19:0] count;
  } stats_t;

  localparam stats_t STATS_RST = '{last: 20'h00000, min: 20'h99999, max: 20'h00000, count: 20'h00000};

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   sensor_lvl;
  logic                   sensor_rise;
  logic [17:0]            prescaler;
  logic [17:0]            latched_ticks;
  logic [19:0]            acc;
  stats_t                 stats;
  logic                   start;
  logic                   capture;

  function automatic logic [19:0] bcd_inc(input logic [19:0] v);
    logic [19:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Sensor is asynchronous: synchronise, then compare against a delayed copy for the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sensor};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sensor_lvl  = sync_q[SYNC_STAGES-1];
  assign sensor_rise = sensor_lvl & ~sync_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.starttrigger) state_nxt = MEASURE;
      MEASURE: begin
        // A sensor edge on the timeout cycle still counts as a valid measurement.
        if (sensor_rise)              state_nxt = HOLD;
        else if (acc == TIMEOUT_BCD)  state_nxt = IDLE;
      end
      HOLD:    if (!sensor_lvl) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.measuring = (state == MEASURE);
    start         = (state == IDLE) && bus.starttrigger;
    capture       = (state == MEASURE) && sensor_rise;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler     <= '0;
      latched_ticks <= 18'd1;
      acc           <= '0;
    end else if (start) begin
      prescaler     <= '0;
      acc           <= '0;
      latched_ticks <= (bus.ticks_per_unit == 18'd0) ? 18'd1 : bus.ticks_per_unit;
    end else if (state == MEASURE) begin
      if (prescaler == latched_ticks - 18'd1) begin
        prescaler <= '0;
        acc       <= bcd_inc(acc);
      end else begin
        prescaler <= prescaler + 18'd1;
      end
    end
  end

  // Valid BCD orders the same as plain binary, so unsigned compares suffice.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stats <= STATS_RST;
    end else if (bus.clear_stats) begin
      stats <= STATS_RST;
    end else if (capture) begin
      stats.last <= acc;
      if (acc < stats.min) stats.min <= acc;
      if (acc > stats.max) stats.max <= acc;
      if (stats.count != 20'h99999) stats.count <= bcd_inc(stats.count);
    end
  end

  assign bus.bcdcount = stats;

endmodule

// File: tb/tb_lag_counter.sv
// Directed bench for lag_counter with a scoreboard queue of expected stat words.
// A second instance with a short timeout covers the abandon and sensor-vs-timeout race paths.
module tb_lag_counter;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  lag_counter_if dut_if();
  lag_counter_if to_if();

  lag_counter u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (dut_if.slave)
  );

  lag_counter #(.TIMEOUT_BCD(20'h00050)) u_to (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (to_if.slave)
  );

  always #5 clock = ~clock;

  localparam logic [79:0] CLEARED = {20'h00000, 20'h99999, 20'h00000, 20'h00000};

  int total = 0;
  int bad   = 0;
  logic [79:0] sb_q[$];
  int e_last[2];
  int e_min[2];
  int e_max[2];
  int e_cnt[2];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [79:0] exp_word(input int u);
    return {to_bcd(e_last[u]), to_bcd(e_min[u]), to_bcd(e_max[u]), to_bcd(e_cnt[u])};
  endfunction

  function automatic logic meas(input int u);
    return (u == 1) ? to_if.measuring : dut_if.measuring;
  endfunction

  function automatic logic [79:0] outw(input int u);
    return (u == 1) ? to_if.bcdcount : dut_if.bcdcount;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int u);
    e_last[u] = 0;
    e_min[u]  = 99999;
    e_max[u]  = 0;
    e_cnt[u]  = 0;
  endtask

  task automatic model_capture(input int u, input int lag);
    e_last[u] = lag;
    if (lag < e_min[u]) e_min[u] = lag;
    if (lag > e_max[u]) e_max[u] = lag;
    if (e_cnt[u] < 99999) e_cnt[u]++;
    sb_q.push_back(exp_word(u));
  endtask

  task automatic set_sensor(input int u, input logic v);
    if (u == 1) to_if.sensor = v;
    else        dut_if.sensor = v;
  endtask

  task automatic trig_pulse(input int u, input int t);
    if (u == 1) begin
      to_if.ticks_per_unit = 18'(t);
      to_if.starttrigger   = 1'b1;
    end else begin
      dut_if.ticks_per_unit = 18'(t);
      dut_if.starttrigger   = 1'b1;
    end
    step();
    to_if.starttrigger  = 1'b0;
    dut_if.starttrigger = 1'b0;
  endtask

  // Bounded wait for the end of MEASURE, then compare against the oldest expectation.
  task automatic collect(input int u, input string tag);
    int n;
    logic [79:0] exp;
    n = 0;
    while (meas(u) && n < 20) begin
      step();
      n++;
    end
    chk({tag, ":done"}, 80'(meas(u)), 80'd0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    chk({tag, ":stats"}, outw(u), exp);
  endtask

  // Sensor driven just after edge s of the measurement (edge 0 samples the trigger);
  // it is consumed SYNC_STAGES+1 edges later, so the captured lag is (s+2)/ticks.
  task automatic measure(input int u, input int t, input int s, input string tag);
    int teff;
    teff = (t == 0) ? 1 : t;
    trig_pulse(u, t);
    chk({tag, ":meas_hi"}, 80'(meas(u)), 80'd1);
    repeat (s) step();
    model_capture(u, (s + 2) / teff);
    set_sensor(u, 1'b1);
    collect(u, tag);
    set_sensor(u, 1'b0);
    repeat (4) step();
    chk({tag, ":idle"}, 80'(meas(u)), 80'd0);
  endtask

  initial begin
    dut_if.starttrigger   = 1'b0;
    dut_if.sensor         = 1'b0;
    dut_if.ticks_per_unit = 18'd1;
    dut_if.clear_stats    = 1'b0;
    to_if.starttrigger    = 1'b0;
    to_if.sensor          = 1'b0;
    to_if.ticks_per_unit  = 18'd1;
    to_if.clear_stats     = 1'b0;
    model_clear(0);
    model_clear(1);

    #12;
    chk("rst_meas", 80'(dut_if.measuring), 80'd0);
    chk("rst_stats", dut_if.bcdcount, CLEARED);
    chk("rst_stats_to", to_if.bcdcount, CLEARED);
    reset_n = 1'b1;
    step();

    // Basic measurement, ticks_per_unit = 4: lag 51/4 = 12.
    measure(0, 4, 49, "basic");

    dut_if.clear_stats = 1'b1;
    step();
    dut_if.clear_stats = 1'b0;
    model_clear(0);
    chk("clear_pulse", dut_if.bcdcount, CLEARED);

    // Min/max tracking over 20, 100, 60 units.
    measure(0, 1, 18, "mm20");
    measure(0, 1, 98, "mm100");
    measure(0, 1, 58, "mm60");
    chk("mm_final", dut_if.bcdcount, {20'h00060, 20'h00020, 20'h00100, 20'h00003});

    // Zero ticks_per_unit behaves as one.
    measure(0, 0, 5, "tpu0");

    // BCD carry: every accumulator value up to 01000 checked.
    trig_pulse(0, 1);
    for (int k = 1; k <= 1000; k++) begin
      step();
      chk($sformatf("acc%0d", k), {60'd0, u_dut.acc}, {60'd0, to_bcd(k)});
      if (k == 998) begin
        model_capture(0, 1000);
        dut_if.sensor = 1'b1;
      end
    end
    collect(0, "carry");
    dut_if.sensor = 1'b0;
    repeat (4) step();

    // Sensor already lit at trigger: only a fresh rise after a fall is captured.
    dut_if.sensor = 1'b1;
    repeat (4) step();
    trig_pulse(0, 1);
    chk("prelit_meas", 80'(dut_if.measuring), 80'd1);
    repeat (20) step();
    chk("prelit_still", 80'(dut_if.measuring), 80'd1);
    chk("prelit_stats", dut_if.bcdcount, exp_word(0));
    dut_if.sensor = 1'b0;
    repeat (4) step();
    model_capture(0, 26);
    dut_if.sensor = 1'b1;
    collect(0, "prelit");
    // Trigger while HOLD keeps the sensor lit is ignored.
    trig_pulse(0, 1);
    repeat (3) step();
    chk("hold_trig_meas", 80'(dut_if.measuring), 80'd0);
    chk("hold_trig_stats", dut_if.bcdcount, exp_word(0));
    dut_if.sensor = 1'b0;
    repeat (4) step();
    chk("hold_exit_meas", 80'(dut_if.measuring), 80'd0);

    // Timeout instance: prior stats, sensor/timeout race, then abandoned run.
    measure(1, 1, 8, "to_pre");
    measure(1, 1, 48, "to_race");
    trig_pulse(1, 1);
    repeat (50) step();
    chk("to_at_limit", 80'(to_if.measuring), 80'd1);
    step();
    chk("to_abandon", 80'(to_if.measuring), 80'd0);
    chk("to_stats", to_if.bcdcount, exp_word(1));
    chk("to_count", {60'd0, to_if.bcdcount[19:0]}, {60'd0, 20'h00002});

    // clear_stats on the capture edge wins over the update.
    trig_pulse(0, 1);
    repeat (10) step();
    dut_if.sensor = 1'b1;
    repeat (2) step();
    dut_if.clear_stats = 1'b1;
    step();
    dut_if.clear_stats = 1'b0;
    model_clear(0);
    chk("clr_race_meas", 80'(dut_if.measuring), 80'd0);
    chk("clr_race_stats", dut_if.bcdcount, CLEARED);
    dut_if.sensor = 1'b0;
    repeat (4) step();

    // Asynchronous reset in the middle of MEASURE.
    measure(0, 1, 3, "pre_rst");
    trig_pulse(0, 1);
    repeat (5) step();
    chk("mid_meas", 80'(dut_if.measuring), 80'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_meas", 80'(dut_if.measuring), 80'd0);
    chk("arst_stats", dut_if.bcdcount, CLEARED);
    chk("arst_stats_to", to_if.bcdcount, CLEARED);
    model_clear(0);
    model_clear(1);
    #1 reset_n = 1'b1;
    step();
    measure(0, 2, 10, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
